// File: rtl/view_controller.sv
`default_nettype none
// view_controller: frame-strobed pan/zoom/iteration controller with an automatic zoom demo.
// Rev 1.0
module view_controller #(
  parameter int COORD_WIDTH   = 16,
  parameter int ZOOM_WIDTH    = 8,
  parameter int ITER_WIDTH    = 6,
  parameter int MAX_ZOOM      = 24,
  parameter int BASE_PAN_STEP = 410,
  parameter int COORD_MIN     = -8192,
  parameter int COORD_MAX     = 8192,
  parameter int ACCEL_FRAMES  = 8,
  parameter int DEMO_PERIOD   = 4,
  parameter int DEMO_X        = -3072,
  parameter int DEMO_Y        = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          v_begin,
  input  logic [7:0]                    ui_in,
  input  logic [7:0]                    uio_in,
  output logic signed [COORD_WIDTH-1:0] centre_x,
  output logic signed [COORD_WIDTH-1:0] centre_y,
  output logic [ZOOM_WIDTH-1:0]         zoom_level,
  output logic [ITER_WIDTH-1:0]         max_iter_limit,
  output logic                          params_updated
);

  localparam int c_ext_w  = COORD_WIDTH + 2;
  localparam int c_hold_w = $clog2(ACCEL_FRAMES + 1);
  localparam int c_fcnt_w = (DEMO_PERIOD > 1) ? $clog2(DEMO_PERIOD) : 1;

  localparam logic signed [c_ext_w-1:0]     c_min    = c_ext_w'(COORD_MIN);
  localparam logic signed [c_ext_w-1:0]     c_max    = c_ext_w'(COORD_MAX);
  localparam logic signed [COORD_WIDTH-1:0] c_home_x = COORD_WIDTH'(-2048);
  localparam logic signed [COORD_WIDTH-1:0] c_demo_x = COORD_WIDTH'(DEMO_X);
  localparam logic signed [COORD_WIDTH-1:0] c_demo_y = COORD_WIDTH'(DEMO_Y);
  localparam logic [ITER_WIDTH-1:0]         c_iter_max = {ITER_WIDTH{1'b1}};
  localparam logic [ZOOM_WIDTH-1:0]         c_zoom_max = ZOOM_WIDTH'(MAX_ZOOM);
  localparam logic [c_hold_w-1:0]           c_accel    = c_hold_w'(ACCEL_FRAMES);
  localparam logic [c_fcnt_w-1:0]           c_fcnt_last = c_fcnt_w'(DEMO_PERIOD - 1);

  typedef enum logic [1:0] {
    MANUAL   = 2'd0,
    DEMO_IN  = 2'd1,
    DEMO_OUT = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [6:0]                      ui_s1_q, ui_s2_q;
  logic [2:0]                      cfg_s1_q, cfg_s2_q;
  logic signed [COORD_WIDTH-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [ZOOM_WIDTH-1:0]           zoom_q, zoom_d;
  logic [ITER_WIDTH-1:0]           iter_q, iter_d;
  logic [c_hold_w-1:0]             hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  logic [c_fcnt_w-1:0]             fcnt_q, fcnt_d;
  logic                            upd_q, upd_d;

  logic                            w_unused;
  logic                            w_zin, w_zout, w_left, w_right, w_up, w_down, w_rview, w_demo;
  logic [3:0]                      w_shamt;
  logic [c_ext_w-1:0]              w_step_base, w_step, w_step_x, w_step_y;
  logic [ZOOM_WIDTH-1:0]           w_zoom_up, w_zoom_dn;

  assign w_unused = ^{ui_in[7], uio_in[7:3]};

  assign w_zin   = ui_s2_q[0];
  assign w_zout  = ui_s2_q[1];
  assign w_left  = ui_s2_q[2];
  assign w_right = ui_s2_q[3];
  assign w_up    = ui_s2_q[4];
  assign w_down  = ui_s2_q[5];
  assign w_rview = ui_s2_q[6];
  assign w_demo  = cfg_s2_q[2];

  // Step shrinks by half per zoom level, floored at one LSB so deep zoom can still move.
  assign w_shamt     = (zoom_q > ZOOM_WIDTH'(15)) ? 4'd15 : zoom_q[3:0];
  assign w_step_base = c_ext_w'(BASE_PAN_STEP) >> w_shamt;
  assign w_step      = (w_step_base == '0) ? c_ext_w'(1) : w_step_base;
  assign w_step_x    = (hold_x_q >= c_accel) ? (w_step << 2) : w_step;
  assign w_step_y    = (hold_y_q >= c_accel) ? (w_step << 2) : w_step;

  assign w_zoom_up = (zoom_q >= c_zoom_max) ? c_zoom_max : zoom_q + ZOOM_WIDTH'(1);
  assign w_zoom_dn = (zoom_q == '0) ? '0 : zoom_q - ZOOM_WIDTH'(1);

  function automatic logic signed [COORD_WIDTH-1:0] pan_axis(
    input logic signed [COORD_WIDTH-1:0] cur,
    input logic                          dec,
    input logic                          inc,
    input logic [c_ext_w-1:0]            step
  );
    logic signed [c_ext_w-1:0] sum;
    sum = {{2{cur[COORD_WIDTH-1]}}, cur};
    if (dec && !inc) begin
      sum = sum - $signed(step);
    end else if (inc && !dec) begin
      sum = sum + $signed(step);
    end
    if (sum < c_min) begin
      sum = c_min;
    end else if (sum > c_max) begin
      sum = c_max;
    end
    return sum[COORD_WIDTH-1:0];
  endfunction

  function automatic logic [c_hold_w-1:0] hold_next(
    input logic [c_hold_w-1:0] cnt,
    input logic                a,
    input logic                b
  );
    if (a ^ b) begin
      return (cnt >= c_accel) ? cnt : cnt + c_hold_w'(1);
    end
    return '0;
  endfunction

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    zoom_d   = zoom_q;
    iter_d   = iter_q;
    hold_x_d = hold_x_q;
    hold_y_d = hold_y_q;
    fcnt_d   = fcnt_q;
    upd_d    = 1'b0;
    if (v_begin) begin
      iter_d = c_iter_max >> (2'd3 - cfg_s2_q[1:0]);
      case (state_q)
        MANUAL: begin
          if (w_demo) begin
            state_d  = DEMO_IN;
            cx_d     = c_demo_x;
            cy_d     = c_demo_y;
            fcnt_d   = '0;
            hold_x_d = '0;
            hold_y_d = '0;
          end else if (w_rview) begin
            cx_d     = c_home_x;
            cy_d     = '0;
            zoom_d   = '0;
            hold_x_d = '0;
            hold_y_d = '0;
          end else begin
            cx_d     = pan_axis(cx_q, w_left, w_right, w_step_x);
            cy_d     = pan_axis(cy_q, w_up, w_down, w_step_y);
            hold_x_d = hold_next(hold_x_q, w_left, w_right);
            hold_y_d = hold_next(hold_y_q, w_up, w_down);
            if (w_zin && !w_zout) begin
              zoom_d = w_zoom_up;
            end else if (w_zout && !w_zin) begin
              zoom_d = w_zoom_dn;
            end
          end
        end
        default: begin
          if (!w_demo) begin
            state_d = MANUAL;
          end else if (fcnt_q == c_fcnt_last) begin
            fcnt_d = '0;
            // Direction flips on the very step that lands on the bound.
            if (state_q == DEMO_IN) begin
              zoom_d = w_zoom_up;
              if (w_zoom_up == c_zoom_max) state_d = DEMO_OUT;
            end else begin
              zoom_d = w_zoom_dn;
              if (w_zoom_dn == '0) state_d = DEMO_IN;
            end
          end else begin
            fcnt_d = fcnt_q + c_fcnt_w'(1);
          end
        end
      endcase
      upd_d = (cx_d != cx_q) || (cy_d != cy_q) || (zoom_d != zoom_q) || (iter_d != iter_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_s1_q  <= '0;
      ui_s2_q  <= '0;
      cfg_s1_q <= '0;
      cfg_s2_q <= '0;
      state_q  <= MANUAL;
      cx_q     <= c_home_x;
      cy_q     <= '0;
      zoom_q   <= '0;
      iter_q   <= c_iter_max;
      hold_x_q <= '0;
      hold_y_q <= '0;
      fcnt_q   <= '0;
      upd_q    <= 1'b0;
    end else begin
      ui_s1_q  <= ui_in[6:0];
      ui_s2_q  <= ui_s1_q;
      cfg_s1_q <= uio_in[2:0];
      cfg_s2_q <= cfg_s1_q;
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      zoom_q   <= zoom_d;
      iter_q   <= iter_d;
      hold_x_q <= hold_x_d;
      hold_y_q <= hold_y_d;
      fcnt_q   <= fcnt_d;
      upd_q    <= upd_d;
    end
  end

  assign centre_x       = cx_q;
  assign centre_y       = cy_q;
  assign zoom_level     = zoom_q;
  assign max_iter_limit = iter_q;
  assign params_updated = upd_q;

endmodule
`default_nettype wire
